// File: rtl/rsa_modexp_signer.sv
// rsa_modexp_signer
//   RSA signing engine: signature = message^exp mod modulus.
//   Constant-time left-to-right square-and-multiply. Every modular product uses
//   a bit-serial interleaved multiplier that takes WIDTH+1 cycles.
//
//   State table
//     S_IDLE  | waiting for start; operands are latched on accept
//     S_CHECK | one cycle of operand validation; R is set to 1
//     S_SQR   | R = R*R mod N
//     S_MUL   | T = R*M mod N; R takes T only if the current exponent bit is 1
//     S_DONE  | result presented; held until sig_valid && sig_ready
//
//   Ports
//     clk, reset (async, active-high)
//     start/busy                   job request / engine occupied
//     partial, share_id            key mode and shard tag
//     modulus, message             N and M
//     private_exp, partial_exp     exponent sources
//     abort                        cancels a running job
//     sig_valid/sig_ready          result handshake
//     signature, sig_partial, sig_share, sig_error   result fields
module rsa_modexp_signer #(
    parameter int WIDTH      = 256,
    parameter int EXP_WIDTH  = 256,
    parameter int SHARE_ID_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  partial,
    input  logic [SHARE_ID_W-1:0] share_id,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [WIDTH-1:0]      message,
    input  logic [EXP_WIDTH-1:0]  private_exp,
    input  logic [EXP_WIDTH-1:0]  partial_exp,
    input  logic                  abort,
    output logic                  busy,
    output logic                  sig_valid,
    input  logic                  sig_ready,
    output logic [WIDTH-1:0]      signature,
    output logic                  sig_partial,
    output logic [SHARE_ID_W-1:0] sig_share,
    output logic                  sig_error
);

    localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int SW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SQR, S_MUL, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic [WIDTH-1:0]      r_n, r_m, r_r, r_acc, r_b;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic                  r_partial, r_err;
    logic [SHARE_ID_W-1:0] r_share;
    logic [SW-1:0]         r_step;
    logic [BW-1:0]         r_bit;
    logic                  r_sig_valid, r_sig_partial, r_sig_error;
    logic [WIDTH-1:0]      r_signature;
    logic [SHARE_ID_W-1:0] r_sig_share;

    logic                  w_bad, w_last_step, w_handshake;
    logic [WIDTH+1:0]      w_nx, w_dbl, w_s1;
    logic [WIDTH-1:0]      w_s2;

    assign w_bad       = (r_n < WIDTH'(2)) || (r_m >= r_n);
    assign w_last_step = (r_step == SW'(WIDTH));
    assign w_handshake = r_sig_valid && sig_ready;

    // acc < N on entry, so 2*acc + a < 3N: two conditional subtractions suffice.
    assign w_nx  = {2'b00, r_n};
    assign w_dbl = {1'b0, r_acc, 1'b0} + (r_b[WIDTH-1] ? {2'b00, r_r} : '0);
    assign w_s1  = (w_dbl >= w_nx) ? w_dbl - w_nx : w_dbl;
    assign w_s2  = WIDTH'((w_s1 >= w_nx) ? w_s1 - w_nx : w_s1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_bad ? S_DONE : S_SQR;
            S_SQR:   if (w_last_step) w_state_next = S_MUL;
            S_MUL:   if (w_last_step) w_state_next = (r_bit == '0) ? S_DONE : S_SQR;
            S_DONE:  if (w_handshake) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (abort && (r_state == S_CHECK || r_state == S_SQR || r_state == S_MUL))
            w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n           <= '0;
            r_m           <= '0;
            r_r           <= '0;
            r_acc         <= '0;
            r_b           <= '0;
            r_exp         <= '0;
            r_partial     <= 1'b0;
            r_err         <= 1'b0;
            r_share       <= '0;
            r_step        <= '0;
            r_bit         <= '0;
            r_sig_valid   <= 1'b0;
            r_sig_partial <= 1'b0;
            r_sig_error   <= 1'b0;
            r_signature   <= '0;
            r_sig_share   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_n       <= modulus;
                    r_m       <= message;
                    r_partial <= partial;
                    r_share   <= partial ? share_id : '0;
                    r_exp     <= partial ? partial_exp : private_exp;
                    r_err     <= 1'b0;
                end
                S_CHECK: begin
                    r_err  <= w_bad;
                    r_r    <= WIDTH'(1);
                    r_bit  <= BW'(EXP_WIDTH - 1);
                    r_step <= '0;
                end
                S_SQR, S_MUL: begin
                    if (r_step == '0) begin
                        // load cycle: multiplier operand is R for squaring, M otherwise
                        r_acc  <= '0;
                        r_b    <= (r_state == S_SQR) ? r_r : r_m;
                        r_step <= SW'(1);
                    end else begin
                        r_acc <= w_s2;
                        r_b   <= r_b << 1;
                        if (w_last_step) begin
                            r_step <= '0;
                            if (r_state == S_SQR) begin
                                r_r <= w_s2;
                            end else begin
                                if (r_exp[EXP_WIDTH-1]) r_r <= w_s2;
                                r_exp <= r_exp << 1;
                                r_bit <= r_bit - BW'(1);
                            end
                        end else begin
                            r_step <= r_step + SW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!r_sig_valid) begin
                        r_sig_valid   <= 1'b1;
                        r_signature   <= r_err ? '0 : r_r;
                        r_sig_error   <= r_err;
                        r_sig_partial <= r_partial;
                        r_sig_share   <= r_share;
                    end else if (w_handshake) begin
                        r_sig_valid   <= 1'b0;
                        r_signature   <= '0;
                        r_sig_error   <= 1'b0;
                        r_sig_partial <= 1'b0;
                        r_sig_share   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign sig_valid   = r_sig_valid;
    assign signature   = r_signature;
    assign sig_partial = r_sig_partial;
    assign sig_share   = r_sig_share;
    assign sig_error   = r_sig_error;

endmodule
